// File: rtl/riscv_multicycle_core.sv
// Multicycle RV32I/RV32E core: one shared ALU and one unified valid/ready memory port.
// Optional retired-instruction counter output `instret` when RISCV_MC_INSTRET_EN is defined.
module riscv_multicycle_core #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          NREGS        = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        halted,
  output logic [31:0] pc
`ifdef RISCV_MC_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  localparam int RW = $clog2(NREGS);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, oldpc_q, oldpc_d, ir_q, ir_d, data_q, data_d;
  logic [31:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d;
  logic [31:0] rf_q [NREGS];
  logic        rf_we;
  logic [31:0] rf_wdata;

  function automatic logic reg_ok(input logic [4:0] idx);
    return ({27'd0, idx} < NREGS);
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] x, input logic [31:0] y,
                                      input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu = sub ? (x - y) : (x + y);
      3'b111:  alu = x & y;
      3'b110:  alu = x | y;
      3'b010:  alu = {31'd0, $signed(x) < $signed(y)};
      default: alu = 32'd0;
    endcase
  endfunction

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, rs1_val, rs2_val;
  logic alu_f3_ok, is_lw, is_sw, is_r, is_i, is_beq, is_jal;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // Register-index legality is folded into each class so RV32E rejects x16..x31.
  assign alu_f3_ok = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
  assign is_lw  = (opcode == 7'b0000011) && (f3 == 3'b010) && reg_ok(rs1) && reg_ok(rd);
  assign is_sw  = (opcode == 7'b0100011) && (f3 == 3'b010) && reg_ok(rs1) && reg_ok(rs2);
  assign is_r   = (opcode == 7'b0110011) && reg_ok(rs1) && reg_ok(rs2) && reg_ok(rd) &&
                  (((f7 == 7'b0000000) && alu_f3_ok) || ((f7 == 7'b0100000) && (f3 == 3'b000)));
  assign is_i   = (opcode == 7'b0010011) && alu_f3_ok && reg_ok(rs1) && reg_ok(rd);
  assign is_beq = (opcode == 7'b1100011) && (f3 == 3'b000) && reg_ok(rs1) && reg_ok(rs2);
  assign is_jal = (opcode == 7'b1101111) && reg_ok(rd);

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1[RW-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2[RW-1:0]];

  assign mem_valid = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign mem_we    = (state_q == S_MEMWRITE);
  assign mem_addr  = (state_q == S_FETCH) ? {pc_q[31:2], 2'b00} : {aluout_q[31:2], 2'b00};
  assign mem_wdata = b_q;
  assign halted    = (state_q == S_HALT);
  assign pc        = pc_q;

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_VECTOR;
      oldpc_q  <= 32'd0;
      ir_q     <= 32'd0;
      data_q   <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      aluout_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      oldpc_q  <= oldpc_d;
      ir_q     <= ir_d;
      data_q   <= data_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

  // Register file; contents are left undefined by reset.
  always_ff @(posedge clk) begin
    if (rf_we && (rd != 5'd0)) begin
      rf_q[rd[RW-1:0]] <= rf_wdata;
    end
  end

  // Controller next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    oldpc_d  = oldpc_q;
    ir_d     = ir_q;
    data_d   = data_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    rf_we    = 1'b0;
    rf_wdata = 32'd0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          oldpc_d = pc_q;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        a_d      = rs1_val;
        b_d      = rs2_val;
        aluout_d = oldpc_q + imm_b;
        if (is_lw || is_sw) state_d = S_MEMADR;
        else if (is_r)      state_d = S_EXEC_R;
        else if (is_i)      state_d = S_EXEC_I;
        else if (is_beq)    state_d = S_BEQ;
        else if (is_jal)    state_d = S_JAL;
        else                state_d = S_HALT;
      end
      S_MEMADR: begin
        aluout_d = a_q + (is_sw ? imm_s : imm_i);
        state_d  = is_sw ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        if (mem_ready) begin
          data_d  = mem_rdata;
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = data_q;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        if (mem_ready) state_d = S_FETCH;
        else           state_d = S_MEMWRITE;
      end
      S_EXEC_R: begin
        aluout_d = alu(a_q, b_q, f3, ir_q[30]);
        state_d  = S_ALUWB;
      end
      S_EXEC_I: begin
        aluout_d = alu(a_q, imm_i, f3, 1'b0);
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_wdata = aluout_q;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        if (a_q == b_q) pc_d = aluout_q;
        else            pc_d = pc_q;
        state_d = S_FETCH;
      end
      S_JAL: begin
        rf_we    = 1'b1;
        rf_wdata = oldpc_q + 32'd4;
        pc_d     = oldpc_q + imm_j;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

`ifdef RISCV_MC_INSTRET_EN
  logic [31:0] instret_q;
  logic        retire;

  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
                  (state_q == S_JAL) || ((state_q == S_MEMWRITE) && mem_ready);

  // Retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset)       instret_q <= 32'd0;
    else if (retire) instret_q <= instret_q + 32'd1;
    else             instret_q <= instret_q;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core: table of ALU vectors plus hand-written
// sequences for stalls, branches, jal, RV32E illegal registers and mid-request reset.
module tb_riscv_multicycle_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        mem_valid, mem_ready, mem_we, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        reset2 = 1'b1;
  logic        valid2, ready2, we2, halted2;
  logic [31:0] addr2, wdata2, rdata2, pc2;
`ifdef RISCV_MC_INSTRET_EN
  logic [31:0] instret, instret2;
`endif

  riscv_multicycle_core #(.RESET_VECTOR(32'h0000_0000), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .halted(halted), .pc(pc)
`ifdef RISCV_MC_INSTRET_EN
    , .instret(instret)
`endif
  );

  riscv_multicycle_core #(.RESET_VECTOR(32'h0000_1000), .NREGS(16)) dut_e (
    .clk(clk), .reset(reset2), .mem_valid(valid2), .mem_ready(ready2),
    .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2), .mem_rdata(rdata2),
    .halted(halted2), .pc(pc2)
`ifdef RISCV_MC_INSTRET_EN
    , .instret(instret2)
`endif
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Memory model: program image copied in during reset, optional waits on one address.
  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } acc_t;

  logic [31:0] prog [256];
  logic [31:0] mem  [256];
  acc_t        acc_log [$];
  int          cyc, wcnt, hold_cnt;
  int          wait_n = 0;
  logic [31:0] wait_addr = 32'hFFFF_FFF0;

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] = prog[i];
      acc_log.delete();
      cyc = 0; wcnt = 0; hold_cnt = 0;
      mem_ready = 1'b1;
      mem_rdata = 32'd0;
    end else begin
      cyc = cyc + 1;
      if (mem_valid && (mem_addr == wait_addr) && (wcnt < wait_n)) begin
        mem_ready = 1'b0;
        wcnt = wcnt + 1;
      end else begin
        mem_ready = 1'b1;
        wcnt = 0;
      end
      mem_rdata = mem[mem_addr[9:2]];
      if (mem_valid && mem_we && (mem_addr == 32'd8) && (mem_wdata == 32'd12)) hold_cnt++;
      if (mem_valid && mem_ready) begin
        acc_log.push_back('{cyc, mem_addr, mem_we, mem_wdata});
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'd0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output int hcyc);
    hcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (halted) begin
        hcyc = cyc;
        break;
      end
    end
    if (hcyc < 0) begin
      n_tot++;
      $display("FAIL halt_timeout: core did not halt within %0d cycles", budget);
    end
  endtask

  task automatic get_store(input int k, output logic [31:0] a, output logic [31:0] d);
    int n = 0;
    a = 32'hFFFF_FFFF;
    d = 32'hFFFF_FFFF;
    foreach (acc_log[i]) begin
      if (acc_log[i].we) begin
        if (n == k) begin
          a = acc_log[i].addr;
          d = acc_log[i].data;
        end
        n++;
      end
    end
  endtask

  function automatic int fetch_cyc(input logic [31:0] addr);
    foreach (acc_log[i]) if (!acc_log[i].we && acc_log[i].addr == addr) return acc_log[i].cyc;
    return -1000;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ins;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int          hcyc, t0, t1;
    logic [31:0] sa, sd;
    logic        found;
    ready2 = 1'b0;
    rdata2 = 32'd0;

    vecs[0]  = '{32'd5,         32'd7,         enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd12};
    vecs[1]  = '{32'hFFFF_FFFF, 32'd1,         enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd0};
    vecs[2]  = '{32'd3,         32'd5,         enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 32'hFFFF_FFFE};
    vecs[3]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3), 32'hF000_F000};
    vecs[4]  = '{32'h0F0F_0000, 32'h0000_00F0, enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd3), 32'h0F0F_00F0};
    vecs[5]  = '{32'hFFFF_FFFF, 32'd1,         enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 32'd1};
    vecs[6]  = '{32'd1,         32'hFFFF_FFFF, enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 32'd0};
    vecs[7]  = '{32'h8000_0000, 32'h7FFF_FFFF, enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 32'd1};
    vecs[8]  = '{32'd10,        32'd0,         enc_i(12'hFFF, 5'd1, 3'b000, 5'd3, 7'b0010011), 32'd9};
    vecs[9]  = '{32'h1234_5678, 32'd0,         enc_i(12'h0FF, 5'd1, 3'b111, 5'd3, 7'b0010011), 32'h0000_0078};
    vecs[10] = '{32'h1234_0000, 32'd0,         enc_i(12'h800, 5'd1, 3'b110, 5'd3, 7'b0010011), 32'hFFFF_F800};
    vecs[11] = '{32'hFFFF_FFFE, 32'd0,         enc_i(12'hFFF, 5'd1, 3'b010, 5'd3, 7'b0010011), 32'd1};

    // ALU table: lw x1; lw x2; op x3; sw x3,0x108; illegal.
    for (int v = 0; v < 12; v++) begin
      clear_prog();
      prog[0]  = enc_i(12'h100, 5'd0, 3'b010, 5'd1, 7'b0000011);
      prog[1]  = enc_i(12'h104, 5'd0, 3'b010, 5'd2, 7'b0000011);
      prog[2]  = vecs[v].ins;
      prog[3]  = enc_s(12'h108, 5'd3, 5'd0);
      prog[64] = vecs[v].a;
      prog[65] = vecs[v].b;
      do_reset();
      run_to_halt(100, hcyc);
      get_store(0, sa, sd);
      chk($sformatf("vec%0d_result", v), sd, vecs[v].exp);
      chk($sformatf("vec%0d_addr", v), sa, 32'h108);
      chk($sformatf("vec%0d_cycles", v), 32'(hcyc), 32'd21);
    end
    chk("halt_mem_valid", {31'd0, mem_valid}, 32'd0);

    // addi/addi/add timing, then store x3.
    clear_prog();
    prog[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
    prog[1] = enc_i(12'd7, 5'd0, 3'b000, 5'd2, 7'b0010011);
    prog[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    prog[3] = enc_s(12'h100, 5'd3, 5'd0);
    do_reset();
    @(negedge clk); #1;
    chk("reset_fetch_valid", {31'd0, mem_valid}, 32'd1);
    chk("reset_fetch_addr", mem_addr, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    repeat (12) @(negedge clk);
    #1;
    chk("seq_cycle13_pc", pc, 32'd12);
    chk("seq_cycle13_addr", mem_addr, 32'd12);
    chk("seq_cycle13_valid", {31'd0, mem_valid}, 32'd1);
    run_to_halt(100, hcyc);
    get_store(0, sa, sd);
    chk("seq_x3", sd, 32'd12);
    chk("seq_halt_cycle", 32'(hcyc), 32'd19);
`ifdef RISCV_MC_INSTRET_EN
    chk("seq_instret", instret, 32'd4);
`endif

    // sw then lw at address 8, two wait cycles each.
    clear_prog();
    prog[0]  = enc_i(12'd12, 5'd0, 3'b000, 5'd3, 7'b0010011);
    prog[1]  = enc_j(21'h3C, 5'd0);
    prog[16] = enc_s(12'h008, 5'd3, 5'd0);
    prog[17] = enc_i(12'h008, 5'd0, 3'b010, 5'd4, 7'b0000011);
    prog[18] = enc_s(12'h10C, 5'd4, 5'd0);
    wait_addr = 32'd8;
    wait_n    = 2;
    do_reset();
    run_to_halt(200, hcyc);
    chk("stall_hold_cycles", 32'(hold_cnt), 32'd3);
    chk("stall_sw_cycles", 32'(fetch_cyc(32'h44) - fetch_cyc(32'h40)), 32'd6);
    chk("stall_lw_cycles", 32'(fetch_cyc(32'h48) - fetch_cyc(32'h44)), 32'd7);
    get_store(1, sa, sd);
    chk("stall_x4_addr", sa, 32'h10C);
    chk("stall_x4", sd, 32'd12);
    wait_addr = 32'hFFFF_FFF0;
    wait_n    = 0;

    // beq taken backwards, then not taken.
    clear_prog();
    prog[0] = enc_i(12'd4, 5'd0, 3'b000, 5'd1, 7'b0010011);
    prog[1] = enc_i(12'd4, 5'd0, 3'b000, 5'd2, 7'b0010011);
    prog[2] = enc_j(21'h18, 5'd0);
    prog[6] = enc_i(12'd9, 5'd0, 3'b000, 5'd1, 7'b0010011);
    prog[7] = enc_j(21'h4, 5'd0);
    prog[8] = enc_b(13'h1FF8, 5'd2, 5'd1);
    do_reset();
    run_to_halt(200, hcyc);
    chk("beq_nacc", 32'(acc_log.size()), 32'd8);
    if (acc_log.size() >= 8) begin
      chk("beq_taken_target", acc_log[4].addr, 32'h18);
      chk("beq_nottaken_target", acc_log[7].addr, 32'h24);
      chk("beq_cycles", 32'(acc_log[4].cyc - acc_log[3].cyc), 32'd3);
      chk("jal_cycles", 32'(acc_log[3].cyc - acc_log[2].cyc), 32'd3);
    end

    // jal x5,+16 at 0x40; x0 must stay zero.
    clear_prog();
    prog[0]  = enc_j(21'h40, 5'd0);
    prog[16] = enc_j(21'h10, 5'd5);
    prog[20] = enc_s(12'h100, 5'd5, 5'd0);
    prog[21] = enc_s(12'h104, 5'd0, 5'd0);
    do_reset();
    run_to_halt(200, hcyc);
    found = (acc_log.size() >= 3);
    chk("jal_next_fetch", found ? acc_log[2].addr : 32'hFFFF_FFFF, 32'h50);
    get_store(0, sa, sd);
    chk("jal_link", sd, 32'h44);
    get_store(1, sa, sd);
    chk("jal_x0", sd, 32'd0);

    // Reset during a stalled read.
    clear_prog();
    prog[0]  = enc_i(12'h100, 5'd0, 3'b010, 5'd1, 7'b0000011);
    prog[1]  = enc_i(12'h008, 5'd0, 3'b010, 5'd2, 7'b0000011);
    prog[64] = 32'hDEAD_BEEF;
    wait_addr = 32'd8;
    wait_n    = 1000;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk); #1;
      found = mem_valid && !mem_we && (mem_addr == 32'd8);
    end
    chk("midreset_reached_stall", {31'd0, found}, 32'd1);
    repeat (2) @(negedge clk);
    #1;
    chk("midreset_stall_data", dut.data_q, 32'hDEAD_BEEF);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    chk("midreset_valid", {31'd0, mem_valid}, 32'd1);
    chk("midreset_addr", mem_addr, 32'd0);
    chk("midreset_pc", pc, 32'd0);
    chk("midreset_data", dut.data_q, 32'd0);
`ifdef RISCV_MC_INSTRET_EN
    chk("midreset_instret", instret, 32'd0);
`endif
    wait_addr = 32'hFFFF_FFF0;
    wait_n    = 0;

    // RV32E: add x20,x1,x2 is illegal.
    ready2 = 1'b1;
    rdata2 = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd20);
    @(posedge clk); #1 reset2 = 1'b0;
    @(negedge clk);
    chk("e_fetch_valid", {31'd0, valid2}, 32'd1);
    chk("e_fetch_addr", addr2, 32'h1000);
    @(negedge clk);
    chk("e_decode_valid", {31'd0, valid2}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("e_halted_%0d", i), {31'd0, halted2}, 32'd1);
      chk($sformatf("e_halt_valid_%0d", i), {31'd0, valid2}, 32'd0);
    end
`ifdef RISCV_MC_INSTRET_EN
    chk("e_instret", instret2, 32'd0);
`endif
    @(posedge clk); #1 reset2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("e_reset_valid", {31'd0, valid2}, 32'd1);
    chk("e_reset_addr", addr2, 32'h1000);
    chk("e_reset_halted", {31'd0, halted2}, 32'd0);
    chk("e_reset_pc", pc2, 32'h1000);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_core.md
# riscv_multicycle_core

Multicycle RV32I core: a sequential datapath plus FSM controller that shares one ALU and one unified memory port across instruction phases. It is the next generation of the team's single-cycle datapath. Differences from that datapath:
- It stalls on a valid/ready memory handshake.
- Register-file depth is parametrisable (RV32I or RV32E).
- It halts cleanly on unsupported encodings.

It sits between the instruction/data memory arbiter and the debug/perf block.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- NREGS, 32: architectural register count; legal values are 16 (RV32E) or 32.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mem_valid  out  1  memory request strobe.
- mem_ready  in  1  memory completes the request this cycle.
- mem_we  out  1  1 = store, 0 = load or fetch.
- mem_addr  out  32  byte address; bits [1:0] are always 0.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; valid in the cycle where mem_valid & mem_ready & !mem_we.
- halted  out  1  core stopped on an illegal instruction.
- pc  out  32  current PC register.

## Operation
Supported instructions:
- lw, sw
- add, sub, and, or, slt
- addi, andi, ori, slti
- beq, jal
- Anything else is illegal.

A register index of NREGS or above is also illegal.

Registers:
- x0 reads as 0; writes to x0 are dropped.
- Architectural registers: PC, OldPC, IR, Data, A, B, ALUOut.

FSM states:
- FETCH: mem_valid=1, mem_addr=PC. When mem_ready: IR←rdata, OldPC←PC, PC←PC+4, go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - A←rf[rs1], B←rf[rs2], ALUOut←OldPC+immB.
  - Next state by opcode: lw/sw→MEMADR; R-type→EXEC_R; I-ALU→EXEC_I; beq→BEQ; jal→JAL; illegal→HALT.
- MEMADR: ALUOut←A+immI (lw) or A+immS (sw). Then → MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_valid=1, addr=ALUOut. When ready: Data←rdata, → MEMWB.
- MEMWB: rd←Data, → FETCH.
- MEMWRITE: mem_valid=1, mem_we=1, addr=ALUOut, wdata=B. When ready → FETCH.
- EXEC_R / EXEC_I: ALUOut←A op B / A op immI, → ALUWB.
- ALUWB: rd←ALUOut, → FETCH.
- BEQ: if A==B then PC←ALUOut. → FETCH.
- JAL: rd←OldPC+4, PC←OldPC+immJ, → FETCH.
- HALT: terminal. halted=1, mem_valid=0. Exits only on reset.

Arithmetic:
- Arithmetic is 32-bit, with wrap-around on add/sub.
- slt is a signed compare.
- Immediates are sign-extended per the RV32I formats.

Address rules:
- lw/sw to a non-word-aligned address drives mem_addr with [1:0] cleared (no trap).
- PC wraps 32'hFFFF_FFFC→0.

## Timing
- Cycles per instruction, zero-wait memory: lw 5, sw 4, R/I-ALU 4, beq 3, jal 3.
- Each wait cycle (mem_valid & !mem_ready) adds one cycle. All outputs, and mem_addr/mem_we/mem_wdata, are held stable while waiting.
- mem_valid never drops before its request is accepted, except on reset.
- Register writes take effect at the clock edge that ends MEMWB, ALUWB or JAL. The next instruction's DECODE sees the new value.
- Reset, applied in any state including mid-request:
  - Next cycle: state=FETCH, PC=RESET_VECTOR, halted=0, mem_valid=1 (fetch issued).
  - IR, A, B, ALUOut and Data are cleared to 0.
  - Register-file contents are undefined; software must initialise them.
- mem_ready asserted while mem_valid=0 is ignored.

## Configuration
- RISCV_MC_INSTRET_EN: adds output `instret`, 32 bits, reset 0.
  - Increments by 1 on the edge leaving MEMWB, MEMWRITE, ALUWB, BEQ or JAL.
  - Wraps at 2^32.
  - Does not count in HALT.
- Without the macro, the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset, then addi x1,x0,5; addi x2,x0,7; add x3,x1,x2 with zero-wait memory → x3=12; total 12 cycles after the first fetch; pc=RESET_VECTOR+12.
- sw x3,8(x0), then lw x4,8(x0) with mem_ready low for 2 cycles on each access → mem_addr=8, mem_wdata=12 held for 3 cycles; x4=12; lw takes 7 cycles.
- beq x1,x1,-8 at PC 0x20 → next fetch address 0x18. With unequal operands → next fetch address 0x24.
- jal x5,+16 at 0x40 → x5=0x44, next fetch 0x50. jal x0 leaves x0=0.
- NREGS=16: add x20,x1,x2 → halted=1 after DECODE, mem_valid stays 0. Reset recovers: fetch at RESET_VECTOR the next cycle.
- Reset asserted during a stalled MEMREAD → next cycle FETCH at RESET_VECTOR, Data=0. With RISCV_MC_INSTRET_EN defined, instret=0.
